// File: rtl/rv_frontend_pipe.sv
// RV32I front-end pipeline registers: PC, IF/ID and ID/EX with stall, flush and redirect handling.
// Optional performance counters are built when PIPE_PERF_CNT_EN is defined.
module rv_frontend_pipe #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        PCWrite,
  input  logic        stall_IF_ID,
  input  logic        flush_IF_ID,
  input  logic        flush_ID_EX,
  input  logic        branch_taken_ID,
  input  logic [31:0] branch_target_ID,
  input  logic [31:0] instr_IF,
  input  logic [4:0]  ctrl_ID,
  input  logic [31:0] imm_ID,
  input  logic [31:0] rs1_data_ID,
  input  logic [31:0] rs2_data_ID,
  output logic [31:0] pc_IF,
  output logic [31:0] instr_ID,
  output logic [31:0] pc_ID,
  output logic        valid_ID,
  output logic [4:0]  rs1_ID,
  output logic [4:0]  rs2_ID,
  output logic [31:0] pc_EX,
  output logic [31:0] imm_EX,
  output logic [31:0] rs1_data_EX,
  output logic [31:0] rs2_data_EX,
  output logic [4:0]  rs1_EX,
  output logic [4:0]  rs2_EX,
  output logic [4:0]  rd_EX,
  output logic [4:0]  ctrl_EX,
  output logic        MemRead_EX,
  output logic        RW_EX,
  output logic        valid_EX,
  output logic [31:0] stall_cnt,
  output logic [31:0] flush_cnt
);

  logic redirect;
  logic flush_if;

  // A branch only redirects when it is a real instruction and the PC is allowed to move.
  assign redirect = branch_taken_ID & valid_ID & PCWrite;
  assign flush_if = flush_IF_ID | redirect;

  assign rs1_ID     = instr_ID[19:15];
  assign rs2_ID     = instr_ID[24:20];
  assign MemRead_EX = ctrl_EX[0];
  assign RW_EX      = ctrl_EX[2];

  always_ff @(posedge clk) begin
    if (rst) begin
      pc_IF <= RESET_PC;
    end else if (PCWrite) begin
      pc_IF <= redirect ? branch_target_ID : pc_IF + 32'd4;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      instr_ID <= NOP_INSTR;
      pc_ID    <= 32'h0;
      valid_ID <= 1'b0;
    end else if (flush_if) begin
      instr_ID <= NOP_INSTR;
      valid_ID <= 1'b0;
    end else if (!stall_IF_ID) begin
      instr_ID <= instr_IF;
      pc_ID    <= pc_IF;
      valid_ID <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ctrl_EX     <= 5'h0;
      rd_EX       <= 5'h0;
      rs1_EX      <= 5'h0;
      rs2_EX      <= 5'h0;
      valid_EX    <= 1'b0;
      pc_EX       <= 32'h0;
      imm_EX      <= 32'h0;
      rs1_data_EX <= 32'h0;
      rs2_data_EX <= 32'h0;
    end else if (flush_ID_EX) begin
      ctrl_EX  <= 5'h0;
      rd_EX    <= 5'h0;
      rs1_EX   <= 5'h0;
      rs2_EX   <= 5'h0;
      valid_EX <= 1'b0;
    end else begin
      ctrl_EX     <= valid_ID ? ctrl_ID : 5'h0;
      // Non-writing instructions never expose rd, so they cannot cause a false load-use stall.
      rd_EX       <= (valid_ID & ctrl_ID[2]) ? instr_ID[11:7] : 5'h0;
      rs1_EX      <= rs1_ID;
      rs2_EX      <= rs2_ID;
      valid_EX    <= valid_ID;
      pc_EX       <= pc_ID;
      imm_EX      <= imm_ID;
      rs1_data_EX <= rs1_data_ID;
      rs2_data_EX <= rs2_data_ID;
    end
  end

`ifdef PIPE_PERF_CNT_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      stall_cnt <= 32'h0;
      flush_cnt <= 32'h0;
    end else begin
      if (!PCWrite) begin
        stall_cnt <= stall_cnt + 32'd1;
      end
      if (flush_if | flush_ID_EX) begin
        flush_cnt <= flush_cnt + 32'd1;
      end
    end
  end
`else
  assign stall_cnt = 32'h0;
  assign flush_cnt = 32'h0;
`endif

endmodule

// File: tb/tb_rv_frontend_pipe.sv
// Scoreboard bench for rv_frontend_pipe: a per-cycle reference model pushes expected
// pipeline state, a monitor pops and compares after every clock edge.
module tb_rv_frontend_pipe;

  localparam logic [31:0] RstPc = 32'h0000_0000;
  localparam logic [31:0] Nop   = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        rst, PCWrite, stall_IF_ID, flush_IF_ID, flush_ID_EX, branch_taken_ID;
  logic [31:0] branch_target_ID, instr_IF, imm_ID, rs1_data_ID, rs2_data_ID;
  logic [4:0]  ctrl_ID;
  logic [31:0] pc_IF, instr_ID, pc_ID, pc_EX, imm_EX, rs1_data_EX, rs2_data_EX;
  logic [31:0] stall_cnt, flush_cnt;
  logic        valid_ID, MemRead_EX, RW_EX, valid_EX;
  logic [4:0]  rs1_ID, rs2_ID, rs1_EX, rs2_EX, rd_EX, ctrl_EX;

  always #5 clk = ~clk;

  rv_frontend_pipe #(.RESET_PC(RstPc), .NOP_INSTR(Nop)) dut (
    .clk(clk), .rst(rst), .PCWrite(PCWrite), .stall_IF_ID(stall_IF_ID),
    .flush_IF_ID(flush_IF_ID), .flush_ID_EX(flush_ID_EX), .branch_taken_ID(branch_taken_ID),
    .branch_target_ID(branch_target_ID), .instr_IF(instr_IF), .ctrl_ID(ctrl_ID),
    .imm_ID(imm_ID), .rs1_data_ID(rs1_data_ID), .rs2_data_ID(rs2_data_ID),
    .pc_IF(pc_IF), .instr_ID(instr_ID), .pc_ID(pc_ID), .valid_ID(valid_ID),
    .rs1_ID(rs1_ID), .rs2_ID(rs2_ID), .pc_EX(pc_EX), .imm_EX(imm_EX),
    .rs1_data_EX(rs1_data_EX), .rs2_data_EX(rs2_data_EX), .rs1_EX(rs1_EX),
    .rs2_EX(rs2_EX), .rd_EX(rd_EX), .ctrl_EX(ctrl_EX), .MemRead_EX(MemRead_EX),
    .RW_EX(RW_EX), .valid_EX(valid_EX), .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
  );

  // Architectural view of one pipeline snapshot.
  typedef struct {
    logic [31:0] pc;
    logic [31:0] id_instr;
    logic [31:0] id_pc;
    logic        id_valid;
    logic        id_pc_known;
    logic [31:0] ex_pc, ex_imm, ex_d1, ex_d2;
    logic [4:0]  ex_rs1, ex_rs2, ex_rd, ex_ctrl;
    logic        ex_valid;
    logic        ex_data_known;
    logic [31:0] n_stall, n_flush;
  } snap_t;

  snap_t m;
  snap_t sb[$];
  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [159:0] act, input logic [159:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Drive one cycle of inputs and advance the reference model across the coming edge.
  task automatic step(input logic r, input logic pcw, input logic st, input logic fif,
                      input logic fex, input logic bt, input logic [31:0] bta,
                      input logic [31:0] ins, input logic [4:0] ctrl);
    logic  redir;
    snap_t n;
    rst = r; PCWrite = pcw; stall_IF_ID = st; flush_IF_ID = fif; flush_ID_EX = fex;
    branch_taken_ID = bt; branch_target_ID = bta; instr_IF = ins; ctrl_ID = ctrl;
    imm_ID = $urandom; rs1_data_ID = $urandom; rs2_data_ID = $urandom;
    n = m;
    if (r) begin
      n.pc = RstPc; n.id_instr = Nop; n.id_pc = 32'h0; n.id_valid = 1'b0;
      n.id_pc_known = 1'b1;
      n.ex_pc = 0; n.ex_imm = 0; n.ex_d1 = 0; n.ex_d2 = 0;
      n.ex_rs1 = 0; n.ex_rs2 = 0; n.ex_rd = 0; n.ex_ctrl = 0; n.ex_valid = 1'b0;
      n.ex_data_known = 1'b1; n.n_stall = 0; n.n_flush = 0;
    end else begin
      redir = bt && m.id_valid && pcw;
      if (fex) begin
        n.ex_ctrl = 0; n.ex_rd = 0; n.ex_rs1 = 0; n.ex_rs2 = 0; n.ex_valid = 1'b0;
        n.ex_data_known = 1'b0;
      end else begin
        n.ex_ctrl = m.id_valid ? ctrl : 5'h0;
        n.ex_rd = (m.id_valid && ctrl[2]) ? m.id_instr[11:7] : 5'h0;
        n.ex_rs1 = m.id_instr[19:15];
        n.ex_rs2 = m.id_instr[24:20];
        n.ex_valid = m.id_valid;
        n.ex_pc = m.id_pc; n.ex_imm = imm_ID; n.ex_d1 = rs1_data_ID; n.ex_d2 = rs2_data_ID;
        n.ex_data_known = m.id_valid;
      end
      if (fif || redir) begin
        n.id_instr = Nop; n.id_valid = 1'b0; n.id_pc_known = 1'b0;
      end else if (!st) begin
        n.id_instr = ins; n.id_pc = m.pc; n.id_valid = 1'b1; n.id_pc_known = 1'b1;
      end
      if (pcw) n.pc = redir ? bta : m.pc + 32'd4;
`ifdef PIPE_PERF_CNT_EN
      if (!pcw) n.n_stall = m.n_stall + 1;
      if (fif || redir || fex) n.n_flush = m.n_flush + 1;
`else
      n.n_stall = 0; n.n_flush = 0;
`endif
    end
    m = n;
    sb.push_back(n);
  endtask

  task automatic run(input logic pcw, input logic st, input logic fif, input logic fex,
                     input logic bt, input logic [31:0] bta, input logic [31:0] ins,
                     input logic [4:0] ctrl);
    @(negedge clk);
    step(1'b0, pcw, st, fif, fex, bt, bta, ins, ctrl);
  endtask

  // Monitor: one expected snapshot per clock edge.
  initial begin
    snap_t e;
    forever begin
      @(posedge clk);
      #2;
      if (sb.size() > 0) begin
        e = sb.pop_front();
        check("pc_IF", {128'h0, pc_IF}, {128'h0, e.pc});
        check("IF/ID instr,valid", {127'h0, instr_ID, valid_ID}, {127'h0, e.id_instr, e.id_valid});
        check("rs1_ID,rs2_ID", {150'h0, rs1_ID, rs2_ID},
              {150'h0, e.id_instr[19:15], e.id_instr[24:20]});
        if (e.id_pc_known) check("pc_ID", {128'h0, pc_ID}, {128'h0, e.id_pc});
        check("ID/EX ctrl,rd,rs1,rs2,valid,MemRead,RW",
              {133'h0, ctrl_EX, rd_EX, rs1_EX, rs2_EX, valid_EX, MemRead_EX, RW_EX},
              {133'h0, e.ex_ctrl, e.ex_rd, e.ex_rs1, e.ex_rs2, e.ex_valid, e.ex_ctrl[0],
               e.ex_ctrl[2]});
        if (e.ex_data_known)
          check("ID/EX pc,imm,d1,d2", {32'h0, pc_EX, imm_EX, rs1_data_EX, rs2_data_EX},
                {32'h0, e.ex_pc, e.ex_imm, e.ex_d1, e.ex_d2});
        check("stall_cnt,flush_cnt", {96'h0, stall_cnt, flush_cnt},
              {96'h0, e.n_stall, e.n_flush});
      end
    end
  end

  initial begin
    logic [31:0] r;
    logic        pcw, st, fif, fex, bt;
    rst = 1'b1; PCWrite = 1'b1; stall_IF_ID = 0; flush_IF_ID = 0; flush_ID_EX = 0;
    branch_taken_ID = 0; branch_target_ID = 0; instr_IF = 0; ctrl_ID = 0;
    imm_ID = 0; rs1_data_ID = 0; rs2_data_ID = 0;
    m = '{default: '0};

    // Reset for two cycles, then free-run.
    repeat (2) begin
      @(negedge clk);
      step(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, $urandom, 5'h0);
    end
    repeat (4) run(1'b1, 0, 0, 0, 0, 32'h0, $urandom, 5'b00100);

    // Load-use: lw x5 then add x6,x5,x5.
    run(1'b1, 0, 0, 0, 0, 32'h0, 32'h0000_2283, 5'b00100);
    run(1'b1, 0, 0, 0, 0, 32'h0, 32'h0052_8333, 5'b00101);
    run(1'b0, 1, 0, 1, 0, 32'h0, 32'h0000_0000, 5'b00100);
    run(1'b1, 0, 0, 0, 0, 32'h0, $urandom, 5'b00100);
    run(1'b1, 0, 0, 0, 0, 32'h0, $urandom, 5'b00100);

    // Taken branch, and a branch ignored while PCWrite=0.
    run(1'b0, 1, 0, 0, 1, 32'h200, $urandom, 5'b00000);
    run(1'b1, 0, 0, 0, 1, 32'h100, $urandom, 5'b00000);
    run(1'b1, 0, 0, 0, 0, 32'h0, $urandom, 5'b00100);

    // Store with rd field 7 must not expose rd; flush beats stall.
    run(1'b1, 0, 0, 0, 0, 32'h0, 32'h0050_23A3, 5'b00100);
    run(1'b1, 0, 0, 0, 0, 32'h0, $urandom, 5'b00010);
    run(1'b1, 1, 1, 0, 0, 32'h0, $urandom, 5'b00100);

    // Three stalls plus two redirects, then reset in the middle of a stall.
    repeat (3) run(1'b0, 1, 0, 0, 0, 32'h0, $urandom, 5'b00100);
    run(1'b1, 0, 0, 0, 0, 32'h0, $urandom, 5'b00100);
    run(1'b1, 0, 0, 0, 1, 32'h40, $urandom, 5'b00000);
    run(1'b1, 0, 0, 0, 0, 32'h0, $urandom, 5'b00100);
    run(1'b1, 0, 0, 0, 1, 32'h80, $urandom, 5'b00000);
    @(negedge clk);
    step(1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 32'h0, $urandom, 5'h1f);

    // Randomised hazard traffic.
    for (int i = 0; i < 500; i++) begin
      r = $urandom_range(0, 99);
      pcw = 1'b1; st = 1'b0; fif = 1'b0; fex = 1'b0;
      if (r < 15) begin
        pcw = 1'b0; st = 1'b1; fex = 1'b1;
      end else if (r < 20) begin
        fif = 1'b1;
      end else if (r < 30) begin
        pcw = $urandom; st = $urandom; fif = $urandom; fex = $urandom;
      end
      bt = ($urandom_range(0, 99) < 20);
      @(negedge clk);
      step(($urandom_range(0, 99) < 2), pcw, st, fif, fex, bt,
           {$urandom_range(0, 32'h3fff_ffff), 2'b00}, $urandom, 5'($urandom));
    end

    @(posedge clk);
    #4;
    check("scoreboard drained", {128'h0, 32'(sb.size())}, 160'h0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
